// File: rtl/bitpos_pkg.sv
// Shared types and helpers for the bit-position to one-hot generator.
// Holds the two-state walk FSM type and the wrapping position step.
package bitpos_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Width of a position field able to address every lane of a WIDTH-bit word.
  function automatic int pos_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // One walk step, wrapping modulo width (not modulo 2**POS_W).
  // dir = 0 walks toward the MSB, dir = 1 toward the LSB.
  function automatic int next_pos(input int pos, input logic dir, input int width);
    if (!dir) begin
      return (pos >= width - 1) ? 0 : pos + 1;
    end
    return (pos == 0) ? width - 1 : pos - 1;
  endfunction

endpackage

// File: rtl/bitpos_onehot_dec.sv
// Combinational position -> one-hot decoder.
// Positions that do not address a lane (pos >= WIDTH) decode to all-zero.
module bitpos_onehot_dec
  import bitpos_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int POS_W = pos_width(WIDTH)
) (
  input  logic [POS_W-1:0] pos,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = (pos == POS_W'(i));
    end
  end

endmodule

// File: rtl/bitpos_onehot_gen.sv
// Accepts a start position plus walk length and emits registered one-hot beats,
// stepping up or down with wrap modulo WIDTH, one beat per accepted out handshake.
module bitpos_onehot_gen
  import bitpos_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int POS_W = pos_width(WIDTH),
  parameter int CNT_W = POS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_pos,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] onehot_out,
  output logic [POS_W-1:0] out_pos,
  output logic             out_last,
  output logic             cmd_err,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // cmd_ready depends on state only; out_valid and all beat outputs are registered
  // and stay frozen while out_valid & !out_ready.

  state_t           state_q, state_d;
  logic [POS_W-1:0] cur_q, cur_d;
  logic [POS_W-1:0] step_pos, dec_pos;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] word_q, word_d, dec_word;
  logic             accept, beat, pos_legal;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign beat      = valid_q & out_ready;
  assign pos_legal = (32'(cmd_pos) < WIDTH);
  assign step_pos  = POS_W'(next_pos(32'(cur_q), dir_q, WIDTH));

  // The decoder sees the position that will be loaded at the next edge.
  assign dec_pos = (state_q == IDLE) ? cmd_pos : step_pos;

  bitpos_onehot_dec #(
    .WIDTH (WIDTH),
    .POS_W (POS_W)
  ) u_dec (
    .pos    (dec_pos),
    .onehot (dec_word)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    remain_d = remain_q;
    dir_d    = dir_q;
    valid_d  = valid_q;
    last_d   = last_q;
    err_d    = 1'b0;
    word_d   = word_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (pos_legal) begin
            state_d  = EMIT;
            cur_d    = cmd_pos;
            remain_d = cmd_count;
            dir_d    = cmd_dir;
            valid_d  = 1'b1;
            last_d   = (cmd_count == '0);
            word_d   = dec_word;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (beat) begin
          if (remain_q == '0) begin
            state_d  = IDLE;
            cur_d    = '0;
            dir_d    = 1'b0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            word_d   = '0;
          end else begin
            cur_d    = step_pos;
            remain_d = remain_q - CNT_W'(1);
            valid_d  = 1'b1;
            last_d   = (remain_q == CNT_W'(1));
            word_d   = dec_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      remain_q <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

  assign out_valid  = valid_q;
  assign onehot_out = word_q;
  assign out_pos    = cur_q;
  assign out_last   = last_q;
  assign cmd_err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bitpos_onehot_gen.sv
// Bench for bitpos_onehot_gen: an 8-lane and a 6-lane instance, each checked every
// cycle against a queue of expected beats built from the command rules.
module tb_bitpos_onehot_gen;
  import bitpos_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: WIDTH=8, dut1: WIDTH=6 (both POS_W=3, CNT_W=3)
  logic       cmd_valid0 = 0, cmd_dir0 = 0, out_ready0 = 1;
  logic [2:0] cmd_pos0 = 0, cmd_count0 = 0;
  logic       cmd_ready0, out_valid0, out_last0, cmd_err0;
  logic [7:0] onehot0;
  logic [2:0] out_pos0;
  state_t     dbg0;

  logic       cmd_valid1 = 0, cmd_dir1 = 0, out_ready1 = 1;
  logic [2:0] cmd_pos1 = 0, cmd_count1 = 0;
  logic       cmd_ready1, out_valid1, out_last1, cmd_err1;
  logic [5:0] onehot1;
  logic [2:0] out_pos1;
  state_t     dbg1;

  bitpos_onehot_gen #(.WIDTH(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_pos(cmd_pos0), .cmd_count(cmd_count0), .cmd_dir(cmd_dir0),
    .out_valid(out_valid0), .out_ready(out_ready0), .onehot_out(onehot0),
    .out_pos(out_pos0), .out_last(out_last0), .cmd_err(cmd_err0), .dbg_state(dbg0)
  );

  bitpos_onehot_gen #(.WIDTH(6)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_pos(cmd_pos1), .cmd_count(cmd_count1), .cmd_dir(cmd_dir1),
    .out_valid(out_valid1), .out_ready(out_ready1), .onehot_out(onehot1),
    .out_pos(out_pos1), .out_last(out_last1), .cmd_err(cmd_err1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q [2][$];   // {last, pos} of each beat still owed
  logic [7:0] cap_q [2][$];   // words of beats actually taken
  logic       err_exp [2];
  logic       rst_applied = 1'b0;
  logic       rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string nm(input int d, input string s);
    return $sformatf("dut%0d_%s", d, s);
  endfunction

  // Independent encoder: index of the lowest set bit, -1 for an all-zero word.
  function automatic int encode(input logic [7:0] w);
    for (int i = 0; i < 8; i++) if (w[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input int d, input int width, input logic v, input logic rdy,
                            input logic crdy, input logic cv, input logic [7:0] oh,
                            input logic [2:0] p, input logic l, input logic e,
                            input state_t st, input logic [2:0] cp, input logic [2:0] cc,
                            input logic cd);
    logic [3:0] head;
    logic [7:0] word;
    int pos;
    if (exp_q[d].size() != 0) begin
      head = exp_q[d][0];
      word = 8'd1 << head[2:0];
      chk(nm(d, "out_valid"), 32'(v), 32'(1));
      chk(nm(d, "onehot"), 32'(oh), 32'(word));
      chk(nm(d, "out_pos"), 32'(p), 32'(head[2:0]));
      chk(nm(d, "out_last"), 32'(l), 32'(head[3]));
      chk(nm(d, "roundtrip"), 32'(encode(oh)), 32'(head[2:0]));
    end else begin
      chk(nm(d, "out_valid_idle"), 32'(v), 32'(0));
      chk(nm(d, "onehot_idle"), 32'(oh), 32'(0));
    end
    chk(nm(d, "cmd_ready"), 32'(crdy), 32'(exp_q[d].size() == 0));
    chk(nm(d, "state"), 32'(st), (exp_q[d].size() == 0) ? 32'(IDLE) : 32'(EMIT));
    chk(nm(d, "cmd_err"), 32'(e), 32'(err_exp[d]));
    err_exp[d] = 1'b0;
    if (exp_q[d].size() != 0) begin
      if (rdy) begin
        cap_q[d].push_back(oh);
        void'(exp_q[d].pop_front());
      end
    end else if (cv) begin
      if (int'(cp) < width) begin
        for (int k = 0; k <= int'(cc); k++) begin
          pos = (int'(cp) + (cd ? width - (k % width) : k)) % width;
          exp_q[d].push_back({(k == int'(cc)), 3'(pos)});
        end
      end else begin
        err_exp[d] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (rst_applied) begin
        chk("rst_out_valid0", 32'(out_valid0), 32'(0));
        chk("rst_onehot0", 32'(onehot0), 32'(0));
        chk("rst_out_pos0", 32'(out_pos0), 32'(0));
        chk("rst_out_last0", 32'(out_last0), 32'(0));
        chk("rst_cmd_err1", 32'(cmd_err1), 32'(0));
        chk("rst_out_valid1", 32'(out_valid1), 32'(0));
      end
      exp_q[0].delete();
      exp_q[1].delete();
      err_exp[0] = 1'b0;
      err_exp[1] = 1'b0;
      rst_applied = 1'b1;
    end else begin
      rst_applied = 1'b0;
      model_step(0, 8, out_valid0, out_ready0, cmd_ready0, cmd_valid0, onehot0, out_pos0,
                 out_last0, cmd_err0, dbg0, cmd_pos0, cmd_count0, cmd_dir0);
      model_step(1, 6, out_valid1, out_ready1, cmd_ready1, cmd_valid1, {2'b00, onehot1},
                 out_pos1, out_last1, cmd_err1, dbg1, cmd_pos1, cmd_count1, cmd_dir1);
    end
  end

  // ---------------- driver tasks (entered and left at posedge+#1) ----------------
  task automatic drive(input int d, input logic v, input logic [2:0] p, input logic [2:0] c,
                       input logic dir);
    if (d == 0) begin
      cmd_valid0 = v; cmd_pos0 = p; cmd_count0 = c; cmd_dir0 = dir;
    end else begin
      cmd_valid1 = v; cmd_pos1 = p; cmd_count1 = c; cmd_dir1 = dir;
    end
  endtask

  task automatic send_cmd(input int d, input logic [2:0] p, input logic [2:0] c,
                          input logic dir);
    logic done;
    done = 1'b0;
    drive(d, 1'b1, p, c, dir);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if ((d == 0) ? cmd_ready0 : cmd_ready1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk(nm(d, "cmd_accept_timeout"), 32'(0), 32'(1));
    drive(d, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic wait_idle(input int d);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (d == 0) done = cmd_ready0 && !out_valid0;
      else        done = cmd_ready1 && !out_valid1;
      @(posedge clk);
      #1;
    end
    if (!done) chk(nm(d, "idle_timeout"), 32'(0), 32'(1));
  endtask

  task automatic check_cap(input int d, input string name, input int n, input logic [7:0] w0,
                           input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    w = '{w0, w1, w2, w3};
    chk({name, "_beats"}, 32'(cap_q[d].size()), 32'(n));
    for (int i = 0; i < n && i < cap_q[d].size(); i++)
      chk($sformatf("%s_w%0d", name, i), 32'(cap_q[d][i]), 32'(w[i]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) begin
        out_ready0 = ($urandom_range(0, 3) != 0);
        out_ready1 = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat
    cap_q[0].delete();
    send_cmd(0, 3'd5, 3'd0, 1'b0);
    @(negedge clk);
    chk("single_onehot", 32'(onehot0), 32'h20);
    chk("single_pos", 32'(out_pos0), 32'd5);
    chk("single_last", 32'(out_last0), 32'd1);
    chk("single_ready_low", 32'(cmd_ready0), 32'd0);
    @(negedge clk);
    chk("single_ready_back", 32'(cmd_ready0), 32'd1);
    @(posedge clk);
    #1;
    wait_idle(0);
    check_cap(0, "single", 1, 8'h20, 8'h00, 8'h00, 8'h00);

    // Walk up with wrap
    cap_q[0].delete();
    send_cmd(0, 3'd6, 3'd3, 1'b0);
    wait_idle(0);
    check_cap(0, "walk_up", 4, 8'h40, 8'h80, 8'h01, 8'h02);

    // Walk down with wrap, stall on the second beat
    cap_q[0].delete();
    send_cmd(0, 3'd1, 3'd2, 1'b1);
    @(posedge clk);
    #1;
    out_ready0 = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    out_ready0 = 1'b1;
    wait_idle(0);
    check_cap(0, "walk_down", 3, 8'h02, 8'h01, 8'h80, 8'h00);

    // Illegal position on the 6-lane instance, then a legal wrapping walk
    cap_q[1].delete();
    send_cmd(1, 3'd7, 3'd0, 1'b0);
    @(negedge clk);
    chk("illegal_err_pulse", 32'(cmd_err1), 32'd1);
    chk("illegal_no_valid", 32'(out_valid1), 32'd0);
    @(negedge clk);
    chk("illegal_err_gone", 32'(cmd_err1), 32'd0);
    @(posedge clk);
    #1;
    send_cmd(1, 3'd5, 3'd1, 1'b0);
    wait_idle(1);
    check_cap(1, "w6_wrap", 2, 8'h20, 8'h01, 8'h00, 8'h00);

    // Round trip of every position
    cap_q[0].delete();
    for (int p = 0; p < 8; p++) begin
      send_cmd(0, 3'(p), 3'd0, 1'b0);
      wait_idle(0);
    end
    chk("roundtrip_beats", 32'(cap_q[0].size()), 32'd8);
    for (int p = 0; p < 8 && p < cap_q[0].size(); p++)
      chk($sformatf("roundtrip_pos%0d", p), 32'(encode(cap_q[0][p])), 32'(p));

    // Reset in the middle of a long walk
    send_cmd(0, 3'd0, 3'd7, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready0), 32'd1);
    chk("post_rst_valid", 32'(out_valid0), 32'd0);
    chk("post_rst_onehot", 32'(onehot0), 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_cmd(0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      send_cmd(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    wait_idle(0);
    wait_idle(1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
